matrix_mul_tile: RTL and testbench



---
 rtl/matrix_mul_pkg.sv | 40 ++++
 rtl/matrix_mul_tile_mac_lane.sv | 51 +++++
 rtl/matrix_mul_tile.sv | 172 +++++++++++++++++
 tb/tb_matrix_mul_tile.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mul_pkg.sv
// Shared types and helpers for the tiled signed matrix multiplier.
package matrix_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CONV_PASS = 2'd0,
    CONV_HI   = 2'd1,
    CONV_LO   = 2'd2
  } conv_e;

  // Widest accumulator the conversion helper can classify.
  localparam int unsigned CONV_W = 128;

  // Address width for n entries, never below one bit.
  function automatic int unsigned clog2w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  // Classifies a sign-extended accumulator against the signed out_w range.
  function automatic conv_e conv_sel(input logic signed [CONV_W-1:0] acc,
                                     input int unsigned out_w, input logic sat);
    logic signed [CONV_W-1:0] hi;
    logic signed [CONV_W-1:0] lo;
    hi = (CONV_W'(1) << (out_w - 1)) - CONV_W'(1);
    lo = ~hi;
    if (sat && (acc > hi)) return CONV_HI;
    if (sat && (acc < lo)) return CONV_LO;
    return CONV_PASS;
  endfunction

endpackage

// File: rtl/matrix_mul_tile_mac_lane.sv
// One MAC lane: signed multiply-accumulate with clear and registered saturate/wrap output.
module mac_lane
  import matrix_mul_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned ACC_W = 35,
  parameter int unsigned OUT_W = 32,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             acc_en,
  input  logic             load,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [OUT_W-1:0] res
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        res_q, res_d;
  logic signed [2*DW-1:0]  prod_c;
  logic [OUT_W-1:0]        conv_c;

  always_comb begin
    prod_c = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
    acc_d  = acc_q;
    if (clr) acc_d = '0;
    else if (acc_en) acc_d = acc_q + ACC_W'(prod_c);
    // Output is taken from the post-accumulate value so LAST can latch it directly.
    case (conv_sel(CONV_W'(acc_d), OUT_W, SAT))
      CONV_HI: conv_c = {1'b0, {(OUT_W-1){1'b1}}};
      CONV_LO: conv_c = {1'b1, {(OUT_W-1){1'b0}}};
      default: conv_c = OUT_W'(acc_d);
    endcase
    res_d = load ? conv_c : res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: rtl/matrix_mul_tile.sv
// Tiled C = A x B: LANES result columns per beat, RAM operand fetch, valid/ready result port.
module matrix_mul_tile
  import matrix_mul_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned R_A   = 2,
  parameter int unsigned C_A   = 4,
  parameter int unsigned C_B   = 2,
  parameter int unsigned LANES = 2,
  parameter int unsigned ACC_W = 2*DW + $clog2(C_A) + 1,
  parameter int unsigned OUT_W = 32,
  parameter bit          SAT   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     a_rd,
  output logic [clog2w(R_A)-1:0]   a_row,
  output logic [clog2w(C_A)-1:0]   a_col,
  input  logic [DW-1:0]            a_data,
  output logic                     b_rd,
  output logic [clog2w(C_A)-1:0]   b_row,
  output logic [clog2w(C_B)-1:0]   b_col,
  input  logic [LANES*DW-1:0]      b_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [LANES*OUT_W-1:0]   res_data,
  output logic [clog2w(R_A)-1:0]   res_row,
  output logic [clog2w(C_B)-1:0]   res_col
);

  localparam int unsigned RW = clog2w(R_A);
  localparam int unsigned KW = clog2w(C_A);
  localparam int unsigned CW = clog2w(C_B);

  state_e         state_q, state_d;
  logic [RW-1:0]  i_q, i_d;
  logic [CW-1:0]  jb_q, jb_d;
  logic [KW-1:0]  k_q, k_d;
  logic           rd_q, rd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           valid_q, valid_d;

  logic           last_k_c, last_col_c, last_tile_c;
  logic           clr_c, acc_en_c, load_c;

  // Sequencing: one k per cycle in RUN, one drain cycle in LAST, hold the beat in OUT.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    jb_d    = jb_q;
    k_d     = k_q;
    rd_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = 1'b0;

    last_k_c    = (k_q == KW'(C_A - 1));
    last_col_c  = (jb_q == CW'(C_B - LANES));
    last_tile_c = last_col_c && (i_q == RW'(R_A - 1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          i_d     = '0;
          jb_d    = '0;
          k_d     = '0;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_k_c) begin
          state_d = ST_LAST;
          k_d     = '0;
        end else begin
          k_d  = k_q + KW'(1);
          rd_d = 1'b1;
        end
      end
      ST_LAST: begin
        state_d = ST_OUT;
        valid_d = 1'b1;
      end
      ST_OUT: begin
        valid_d = 1'b1;
        if (res_ready) begin
          valid_d = 1'b0;
          if (last_tile_c) begin
            state_d = ST_IDLE;
            i_d     = '0;
            jb_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            rd_d    = 1'b1;
            if (last_col_c) begin
              jb_d = '0;
              i_d  = i_q + RW'(1);
            end else begin
              jb_d = jb_q + CW'(LANES);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Data for k arrives one cycle after issue, so k=0 of RUN has nothing to add yet.
    acc_en_c = ((state_q == ST_RUN) && (k_q != '0)) || (state_q == ST_LAST);
    load_c   = (state_q == ST_LAST);
    clr_c    = ((state_q == ST_IDLE) && start) || ((state_q == ST_OUT) && res_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      jb_q    <= '0;
      k_q     <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      jb_q    <= jb_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .DW   (DW),
      .ACC_W(ACC_W),
      .OUT_W(OUT_W),
      .SAT  (SAT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_c),
      .acc_en(acc_en_c),
      .load  (load_c),
      .a     (a_data),
      .b     (b_data[l*DW +: DW]),
      .res   (res_data[l*OUT_W +: OUT_W])
    );
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign a_rd      = rd_q;
  assign b_rd      = rd_q;
  assign a_row     = i_q;
  assign a_col     = k_q;
  assign b_row     = k_q;
  assign b_col     = jb_q;
  assign res_valid = valid_q;
  assign res_row   = i_q;
  assign res_col   = jb_q;

endmodule

// File: tb/tb_matrix_mul_tile.sv
// Three configurations (wrap, saturate, single lane) checked against a matrix-level reference model.
module tb_matrix_mul_tile;

  localparam int DW  = 16;
  localparam int R_A = 2;
  localparam int C_A = 4;
  localparam int C_B = 2;
  localparam int OW  = 32;

  logic clk = 1'b0;
  logic rst, start, res_ready;
  always #5 clk = ~clk;

  logic signed [15:0] a_mem [R_A][C_A];
  logic signed [15:0] b_mem [C_A][C_B];

  int n_chk = 0;
  int n_fail = 0;

  logic        rv_w  [3];
  logic        dn_w  [3];
  logic        bs_w  [3];
  logic        rd_w  [3];
  logic [63:0] dat_w [3];
  int          row_w [3];
  int          col_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LN = (g == 2) ? 1 : 2;
    localparam bit SP = (g == 1);
    logic            a_rd, b_rd, busy, done, res_valid;
    logic            a_row, b_col, res_row, res_col;
    logic [1:0]      a_col, b_row;
    logic [DW-1:0]   a_data;
    logic [LN*DW-1:0] b_data;
    logic [LN*OW-1:0] res_data;

    matrix_mul_tile #(
      .DW(DW), .R_A(R_A), .C_A(C_A), .C_B(C_B), .LANES(LN), .OUT_W(OW), .SAT(SP)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .a_rd(a_rd), .a_row(a_row), .a_col(a_col), .a_data(a_data),
      .b_rd(b_rd), .b_row(b_row), .b_col(b_col), .b_data(b_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_row(res_row), .res_col(res_col)
    );

    // Operand RAMs with one-cycle latency; garbage when not read.
    always @(posedge clk) begin
      a_data <= a_rd ? a_mem[a_row][a_col] : 16'($urandom);
      for (int l = 0; l < LN; l++)
        b_data[l*DW +: DW] <= b_rd ? b_mem[b_row][int'(b_col) + l] : 16'($urandom);
    end

    assign rv_w[g]  = res_valid;
    assign dn_w[g]  = done;
    assign bs_w[g]  = busy;
    assign rd_w[g]  = a_rd | b_rd;
    assign dat_w[g] = 64'(res_data);
    assign row_w[g] = int'(res_row);
    assign col_w[g] = int'(res_col);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lanes_of(input int g);
    return (g == 2) ? 1 : 2;
  endfunction

  function automatic bit sat_of(input int g);
    return (g == 1);
  endfunction

  function automatic longint cval(input int i, input int j);
    longint s;
    s = 0;
    for (int k = 0; k < C_A; k++) s += longint'(a_mem[i][k]) * longint'(b_mem[k][j]);
    return s;
  endfunction

  function automatic logic [31:0] conv(input longint v, input bit sat);
    logic [63:0] t;
    if (sat && v > 64'sd2147483647) return 32'h7fffffff;
    if (sat && v < -64'sd2147483648) return 32'h80000000;
    t = v;
    return t[31:0];
  endfunction

  function automatic int n_beats(input int g);
    return R_A * C_B / lanes_of(g);
  endfunction

  function automatic logic [63:0] exp_data(input int g, input int n);
    logic [63:0] d;
    int ln, row, col;
    ln  = lanes_of(g);
    row = n / (C_B / ln);
    col = (n % (C_B / ln)) * ln;
    d = '0;
    for (int l = 0; l < ln; l++) d[l*32 +: 32] = conv(cval(row, col + l), sat_of(g));
    return d;
  endfunction

  bit m_busy [3] = '{3{1'b0}};
  bit m_valid[3] = '{3{1'b0}};
  bit m_done [3] = '{3{1'b0}};
  int m_wait [3] = '{3{0}};
  int m_beat [3] = '{3{0}};

  // Compare against the model, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("res_valid[%0d]", g), 64'(rv_w[g]), 64'(m_valid[g]));
      chk($sformatf("done[%0d]", g), 64'(dn_w[g]), 64'(m_done[g]));
      chk($sformatf("busy[%0d]", g), 64'(bs_w[g]), 64'(m_busy[g]));
      if (!m_busy[g] || m_valid[g]) chk($sformatf("rd_quiet[%0d]", g), 64'(rd_w[g]), 64'd0);
      if (m_valid[g]) begin
        int ln;
        ln = lanes_of(g);
        chk($sformatf("res_data[%0d] beat%0d", g, m_beat[g]), dat_w[g], exp_data(g, m_beat[g]));
        chk($sformatf("res_row[%0d]", g), 64'(row_w[g]), 64'(m_beat[g] / (C_B / ln)));
        chk($sformatf("res_col[%0d]", g), 64'(col_w[g]), 64'((m_beat[g] % (C_B / ln)) * ln));
      end
    end
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        m_busy[g] = 0; m_valid[g] = 0; m_done[g] = 0; m_wait[g] = 0; m_beat[g] = 0;
      end else begin
        m_done[g] = 0;
        if (!m_busy[g]) begin
          if (start) begin
            m_busy[g] = 1; m_valid[g] = 0; m_wait[g] = C_A + 1; m_beat[g] = 0;
          end
        end else if (m_valid[g]) begin
          if (res_ready) begin
            m_valid[g] = 0;
            m_beat[g]++;
            if (m_beat[g] == n_beats(g)) begin
              m_busy[g] = 0;
              m_done[g] = 1;
            end else begin
              m_wait[g] = C_A + 1;
            end
          end
        end else begin
          m_wait[g]--;
          if (m_wait[g] == 0) m_valid[g] = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit any_active();
    bit r;
    r = 0;
    for (int g = 0; g < 3; g++) r |= m_busy[g] | m_done[g];
    return r;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (any_active() && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(n >= budget), 64'd0);
  endtask

  task automatic load_given();
    for (int i = 0; i < R_A; i++)
      for (int k = 0; k < C_A; k++) a_mem[i][k] = 16'(i * C_A + k + 1);
    for (int k = 0; k < C_A; k++)
      for (int j = 0; j < C_B; j++) b_mem[k][j] = 16'(k * C_B + j + 1);
  endtask

  task automatic load_random(input int mode);
    for (int i = 0; i < R_A; i++)
      for (int k = 0; k < C_A; k++)
        case (mode)
          0: a_mem[i][k] = 16'($urandom);
          1: a_mem[i][k] = $urandom_range(0, 1) ? 16'sh8000 : 16'sh7fff;
          2: a_mem[i][k] = 16'(int'($urandom_range(0, 16)) - 8);
          default: a_mem[i][k] = 16'sh8000;
        endcase
    for (int k = 0; k < C_A; k++)
      for (int j = 0; j < C_B; j++)
        case (mode)
          0: b_mem[k][j] = 16'($urandom);
          1: b_mem[k][j] = $urandom_range(0, 1) ? 16'sh8000 : 16'sh7fff;
          2: b_mem[k][j] = 16'(int'($urandom_range(0, 16)) - 8);
          default: b_mem[k][j] = 16'sh8000;
        endcase
  endtask

  task automatic run_product();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(300);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; res_ready = 1'b1;
    load_given();
    repeat (3) tick();
    rst = 1'b0;

    // Hand-computed products pin the model.
    chk("pin_c00", 64'(cval(0, 0)), 64'd50);
    chk("pin_c01", 64'(cval(0, 1)), 64'd60);
    chk("pin_c10", 64'(cval(1, 0)), 64'd114);
    chk("pin_c11", 64'(cval(1, 1)), 64'd140);
    run_product();

    // First beat stalled by the consumer.
    res_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (C_A + 2 + 4) tick();
    res_ready = 1'b1;
    wait_idle(300);

    // Extreme operands: 4 * 2^30 = 2^32.
    load_random(3);
    chk("pin_acc", 64'(cval(0, 0)), 64'h1_0000_0000);
    chk("pin_sat", 64'(conv(cval(0, 0), 1'b1)), 64'h7fff_ffff);
    chk("pin_wrap", 64'(conv(cval(0, 0), 1'b0)), 64'd0);
    run_product();

    // start pulsed while running is ignored.
    load_given();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(300);

    // Reset in the second RUN cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_data", dat_w[0], 64'd0);
    chk("rst_row", 64'(row_w[0]), 64'd0);
    chk("rst_valid", 64'(rv_w[0]), 64'd0);
    run_product();

    // start held across done launches the next product back to back.
    start = 1'b1;
    begin
      int n;
      n = 0;
      while (!m_done[0] && n < 300) begin
        tick();
        n++;
      end
      chk("done_timeout", 64'(n >= 300), 64'd0);
    end
    tick();
    start = 1'b0;
    wait_idle(300);

    // Randomised products with random backpressure, stray starts and occasional reset.
    for (int t = 0; t < 40; t++) begin
      load_random(int'($urandom_range(0, 3)));
      start = 1'b1;
      tick();
      start = 1'b0;
      begin
        int n;
        n = 0;
        while (any_active() && n < 400) begin
          bit all_busy;
          all_busy = m_busy[0] && m_busy[1] && m_busy[2] &&
                     !m_valid[0] && !m_valid[1] && !m_valid[2];
          res_ready = ($urandom_range(0, 3) != 0);
          start = all_busy && ($urandom_range(0, 7) == 0);
          rst = ($urandom_range(0, 199) == 0);
          tick();
          n++;
        end
        rst = 1'b0;
        start = 1'b0;
        res_ready = 1'b1;
        chk("rand_timeout", 64'(n >= 400), 64'd0);
      end
      tick();
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
